// File: rtl/mat_port_arbiter.sv
// rtl/mat_port_arbiter.sv - two-port (host/engine) arbiter for a DIM x DIM matrix memory
// Lockable bursts with a fairness limit, range checking and a 2-stage read-tag pipeline.
module mat_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 4,
   parameter int DIM        = 10,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  h_req,
   input  logic                  h_lock,
   input  logic                  h_we,
   input  logic [ADDR_W-1:0]     h_row,
   input  logic [ADDR_W-1:0]     h_col,
   input  logic [DATA_WIDTH-1:0] h_wdata,
   input  logic                  e_req,
   input  logic                  e_lock,
   input  logic                  e_we,
   input  logic [ADDR_W-1:0]     e_row,
   input  logic [ADDR_W-1:0]     e_col,
   input  logic [DATA_WIDTH-1:0] e_wdata,
   output logic                  h_gnt,
   output logic                  e_gnt,
   output logic                  h_rvalid,
   output logic                  e_rvalid,
   output logic [DATA_WIDTH-1:0] h_rdata,
   output logic [DATA_WIDTH-1:0] e_rdata,
   output logic                  h_err,
   output logic                  e_err,
   output logic                  mem_en_read,
   output logic                  mem_en_write,
   output logic [ADDR_W-1:0]     mem_row,
   output logic [ADDR_W-1:0]     mem_col,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] S_FREE  = 2'd0;
   localparam logic [1:0] S_OWN_H = 2'd1;
   localparam logic [1:0] S_OWN_E = 2'd2;

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);
   localparam logic [ADDR_W:0] DIM_L     = (ADDR_W + 1)'(DIM);

   logic [1:0]            state, state_nxt;
   logic                  last_e, last_e_nxt;
   logic [CW-1:0]         burst, burst_nxt, burst_inc;
   logic                  acc, sel_e, sel_we, sel_lock, other_req, in_range;
   logic [ADDR_W-1:0]     sel_row, sel_col;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  tag1_v, tag1_e, tag2_v, tag2_e;

   // In FREE a tie goes to the port that did not win last time
   always_comb begin
      h_gnt = 1'b0;
      e_gnt = 1'b0;
      case (state)
         S_OWN_H: h_gnt = h_req;
         S_OWN_E: e_gnt = e_req;
         default: begin
            h_gnt = h_req & (~e_req | last_e);
            e_gnt = e_req & ~h_gnt;
         end
      endcase
   end

   assign acc       = h_gnt | e_gnt;
   assign sel_e     = e_gnt;
   assign sel_we    = sel_e ? e_we    : h_we;
   assign sel_lock  = sel_e ? e_lock  : h_lock;
   assign other_req = sel_e ? h_req   : e_req;
   assign sel_row   = sel_e ? e_row   : h_row;
   assign sel_col   = sel_e ? e_col   : h_col;
   assign sel_wdata = sel_e ? e_wdata : h_wdata;
   assign in_range  = ({1'b0, sel_row} < DIM_L) && ({1'b0, sel_col} < DIM_L);

   // burst is always zero in FREE, so one increment covers both the
   // ownership-taking grant and the grants made while owning
   assign burst_inc = burst + CW'(1);

   always_comb begin
      state_nxt  = S_FREE;
      burst_nxt  = '0;
      last_e_nxt = last_e;
      if (acc) begin
         last_e_nxt = sel_e;
         if (sel_lock && !(other_req && (burst_inc >= BURST_MAX))) begin
            state_nxt = sel_e ? S_OWN_E : S_OWN_H;
            burst_nxt = other_req ? burst_inc : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_FREE;
         last_e       <= 1'b1;
         burst        <= '0;
         mem_en_read  <= 1'b0;
         mem_en_write <= 1'b0;
         mem_row      <= '0;
         mem_col      <= '0;
         mem_wdata    <= '0;
         h_err        <= 1'b0;
         e_err        <= 1'b0;
         tag1_v       <= 1'b0;
         tag1_e       <= 1'b0;
         tag2_v       <= 1'b0;
         tag2_e       <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_e       <= last_e_nxt;
         burst        <= burst_nxt;
         mem_en_read  <= acc & in_range & ~sel_we;
         mem_en_write <= acc & in_range & sel_we;
         if (acc && in_range) begin
            mem_row   <= sel_row;
            mem_col   <= sel_col;
            mem_wdata <= sel_wdata;
         end
         h_err  <= h_gnt & ~in_range;
         e_err  <= e_gnt & ~in_range;
         tag1_v <= acc & in_range & ~sel_we;
         tag1_e <= sel_e;
         tag2_v <= tag1_v;
         tag2_e <= tag1_e;
      end
   end

   assign h_rvalid = tag2_v & ~tag2_e;
   assign e_rvalid = tag2_v & tag2_e;
   assign h_rdata  = mem_rdata;
   assign e_rdata  = mem_rdata;

endmodule

// File: tb/tb_mat_port_arbiter.sv
// tb/tb_mat_port_arbiter.sv - self-checking bench for mat_port_arbiter
// Directed scenarios with literal expectations plus randomized traffic against a run-count model.
module tb_mat_port_arbiter;

   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int DIM  = 10;
   localparam int MAXB = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          h_req = 0, h_lock = 0, h_we = 0, e_req = 0, e_lock = 0, e_we = 0;
   logic [AW-1:0] h_row = 0, h_col = 0, e_row = 0, e_col = 0;
   logic [DW-1:0] h_wdata = 0, e_wdata = 0, mem_rdata = 0;
   logic          h_gnt, e_gnt, h_rvalid, e_rvalid, h_err, e_err;
   logic [DW-1:0] h_rdata, e_rdata, mem_wdata;
   logic          mem_en_read, mem_en_write;
   logic [AW-1:0] mem_row, mem_col;

   int checks = 0;
   int failures = 0;

   mat_port_arbiter #(.DATA_WIDTH(DW), .ADDR_W(AW), .DIM(DIM), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset_n(reset_n),
      .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_row(h_row), .h_col(h_col), .h_wdata(h_wdata),
      .e_req(e_req), .e_lock(e_lock), .e_we(e_we), .e_row(e_row), .e_col(e_col), .e_wdata(e_wdata),
      .h_gnt(h_gnt), .e_gnt(e_gnt), .h_rvalid(h_rvalid), .e_rvalid(e_rvalid),
      .h_rdata(h_rdata), .e_rdata(e_rdata), .h_err(h_err), .e_err(e_err),
      .mem_en_read(mem_en_read), .mem_en_write(mem_en_write),
      .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: owner (0 none, 1 host, 2 engine), length of the current
   // contested run, and pending reads with the cycle their data is due.
   typedef struct { int due; bit is_e; } rd_t;
   rd_t           rq[$];
   int            cyc = 0;
   int            owner = 0;
   int            run = 0;
   bit            last_h = 0;
   bit            x_en_r = 0, x_en_w = 0, x_herr = 0, x_eerr = 0;
   logic [AW-1:0] x_row = 0, x_col = 0;
   logic [DW-1:0] x_wd = 0;

   always @(negedge clk) begin : compare
      bit gh, ge, xh_rv, xe_rv, we, lk, oreq;
      int r, c;
      cyc++;
      if (!reset_n) begin
         check("rst_en_read", 32'(mem_en_read), 0);
         check("rst_en_write", 32'(mem_en_write), 0);
         check("rst_row", 32'(mem_row), 0);
         check("rst_col", 32'(mem_col), 0);
         check("rst_wdata", 32'(mem_wdata), 0);
         check("rst_rvalid", 32'({h_rvalid, e_rvalid}), 0);
         check("rst_err", 32'({h_err, e_err}), 0);
         owner = 0; run = 0; last_h = 0;
         x_en_r = 0; x_en_w = 0; x_herr = 0; x_eerr = 0;
         x_row = 0; x_col = 0; x_wd = 0;
         rq.delete();
      end else begin
         xh_rv = 0; xe_rv = 0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].is_e) xe_rv = 1; else xh_rv = 1;
            void'(rq.pop_front());
         end
         check("mem_en_read", 32'(mem_en_read), 32'(x_en_r));
         check("mem_en_write", 32'(mem_en_write), 32'(x_en_w));
         check("mem_row", 32'(mem_row), 32'(x_row));
         check("mem_col", 32'(mem_col), 32'(x_col));
         check("mem_wdata", 32'(mem_wdata), 32'(x_wd));
         check("h_err", 32'(h_err), 32'(x_herr));
         check("e_err", 32'(e_err), 32'(x_eerr));
         check("h_rvalid", 32'(h_rvalid), 32'(xh_rv));
         check("e_rvalid", 32'(e_rvalid), 32'(xe_rv));
         if (xh_rv) check("h_rdata", 32'(h_rdata), 32'(mem_rdata));
         if (xe_rv) check("e_rdata", 32'(e_rdata), 32'(mem_rdata));

         if (owner == 1) begin gh = h_req; ge = 0; end
         else if (owner == 2) begin gh = 0; ge = e_req; end
         else if (h_req && e_req) begin gh = !last_h; ge = last_h; end
         else begin gh = h_req; ge = e_req; end
         check("h_gnt", 32'(h_gnt), 32'(gh));
         check("e_gnt", 32'(e_gnt), 32'(ge));

         x_en_r = 0; x_en_w = 0; x_herr = 0; x_eerr = 0;
         if (gh || ge) begin
            r    = gh ? int'(h_row) : int'(e_row);
            c    = gh ? int'(h_col) : int'(e_col);
            we   = gh ? h_we : e_we;
            lk   = gh ? h_lock : e_lock;
            oreq = gh ? e_req : h_req;
            last_h = gh;
            if (r < DIM && c < DIM) begin
               x_row = AW'(r); x_col = AW'(c); x_wd = gh ? h_wdata : e_wdata;
               if (we) x_en_w = 1;
               else begin x_en_r = 1; rq.push_back('{cyc + 2, ge}); end
            end else if (gh) x_herr = 1;
            else x_eerr = 1;
            if (lk) begin
               owner = gh ? 1 : 2;
               run   = oreq ? run + 1 : 0;
               if (run >= MAXB) begin owner = 0; run = 0; end
            end else begin
               owner = 0; run = 0;
            end
         end else begin
            owner = 0; run = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      h_req = 0; h_lock = 0; h_we = 0; h_row = 0; h_col = 0;
      e_req = 0; e_lock = 0; e_we = 0; e_row = 0; e_col = 0;
   endtask

   bit gh_a[12];
   bit ge_a[12];
   int ecount;

   initial begin
      idle();
      step(); step(); step();
      @(negedge clk);
      check("lit_reset_read", 32'(mem_en_read), 0);
      check("lit_reset_gnt", 32'({h_gnt, e_gnt}), 0);

      // both requesting, no lock: host first then strict alternation
      step(); reset_n = 1; h_req = 1; e_req = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("lit_alt_h", 32'(h_gnt), 32'(i % 2 == 0));
         check("lit_alt_e", 32'(e_gnt), 32'(i % 2 == 1));
         step();
      end

      // host read of (2,3)
      idle(); h_req = 1; h_row = 2; h_col = 3;
      @(negedge clk); check("lit_rd_gnt", 32'(h_gnt), 1);
      step(); idle();
      @(negedge clk);
      check("lit_rd_en", 32'(mem_en_read), 1);
      check("lit_rd_row", 32'(mem_row), 2);
      check("lit_rd_col", 32'(mem_col), 3);
      step(); mem_rdata = 16'h00AB;
      @(negedge clk);
      check("lit_rd_rvalid", 32'(h_rvalid), 1);
      check("lit_rd_data", 32'(h_rdata), 32'h00AB);
      check("lit_rd_e_rvalid", 32'(e_rvalid), 0);
      step(); mem_rdata = 0;
      @(negedge clk); check("lit_rd_once", 32'(h_rvalid), 0);

      // engine locked burst against a continuously requesting host
      step(); e_req = 1; e_lock = 1; h_req = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         gh_a[i] = h_gnt; ge_a[i] = e_gnt;
         step();
      end
      ecount = 0;
      for (int i = 0; i < 8; i++) ecount += int'(ge_a[i]);
      check("lit_burst_len", 32'(ecount), 8);
      check("lit_burst_host", 32'({gh_a[8], ge_a[8]}), 32'b10);
      check("lit_burst_regain", 32'({gh_a[9], ge_a[9]}), 32'b01);

      // engine write out of range
      idle(); e_req = 1; e_we = 1; e_row = 10; e_col = 0;
      @(negedge clk); check("lit_oor_gnt", 32'(e_gnt), 1);
      step(); idle();
      @(negedge clk);
      check("lit_oor_err", 32'(e_err), 1);
      check("lit_oor_strobe", 32'({mem_en_read, mem_en_write}), 0);
      step();
      @(negedge clk); check("lit_oor_pulse", 32'(e_err), 0);

      // alternating reads on four consecutive cycles
      for (int k = 0; k < 6; k++) begin
         step(); idle();
         if (k < 4) begin
            if (k % 2 == 0) begin h_req = 1; h_row = AW'(k + 1); h_col = AW'(k + 1); end
            else begin e_req = 1; e_row = AW'(k + 1); e_col = AW'(k + 1); end
         end
         @(negedge clk);
         if (k >= 2) begin
            check("lit_alt_rv_h", 32'(h_rvalid), 32'(k % 2 == 0));
            check("lit_alt_rv_e", 32'(e_rvalid), 32'(k % 2 == 1));
         end
      end

      // reset right after an accepted read
      step(); idle(); h_req = 1; h_row = 5; h_col = 5;
      @(negedge clk); check("lit_rst_rd_gnt", 32'(h_gnt), 1);
      step(); idle(); reset_n = 0;
      @(negedge clk);
      check("lit_rst_en", 32'({mem_en_read, mem_en_write}), 0);
      check("lit_rst_addr", 32'({mem_row, mem_col}), 0);
      check("lit_rst_wdata", 32'(mem_wdata), 0);
      step(); step(); reset_n = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("lit_rst_no_rv", 32'({h_rvalid, e_rvalid}), 0);
         step();
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         if ($urandom_range(0, 399) == 0) reset_n = 0;
         else reset_n = 1;
         h_req   = ($urandom_range(0, 9) < 7);
         e_req   = ($urandom_range(0, 9) < 7);
         h_lock  = ($urandom_range(0, 9) < 6);
         e_lock  = ($urandom_range(0, 9) < 6);
         h_we    = $urandom_range(0, 1) == 1;
         e_we    = $urandom_range(0, 1) == 1;
         h_row   = AW'($urandom_range(0, 11));
         h_col   = AW'($urandom_range(0, 11));
         e_row   = AW'($urandom_range(0, 11));
         e_col   = AW'($urandom_range(0, 11));
         h_wdata = DW'($urandom);
         e_wdata = DW'($urandom);
         mem_rdata = DW'($urandom);
      end
      step(); reset_n = 1; idle();
      step(); step(); step();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
